uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the data side of the CPU core. It sits on the core's write bus (write_addr/write_data/write_strobe) and its read bus (read_addr, one-cycle-latency read_data).
- Core stores to the TX data register push bytes into a local FIFO.
- A bit-timing FSM drains the FIFO onto o_tx.
- Status is readable with the same registered read latency as block RAM, so the top-level read mux treats this block like RAM.

---
 rtl/uart_tx_mmio_pkg.sv | 28 ++
 rtl/uart_tx_mmio_fifo.sv | 56 +++++
 rtl/uart_tx_mmio.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared MMIO map: peripheral base addresses, UART TX register offsets,
// STATUS bit positions and the UART TX FSM state type.
package uart_tx_mmio_pkg;

  localparam logic [15:0] UART_TX_BASE = 16'h8100;
  localparam logic [15:0] UART_RX_BASE = 16'h8104;
  localparam logic [15:0] TIMER_BASE   = 16'h8108;

  localparam logic [15:0] OFF_TXDATA = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd1;
  localparam logic [15:0] OFF_CTRL   = 16'd2;
  localparam logic [15:0] REG_SPAN   = 16'd4;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_BUSY     = 2;
  localparam int unsigned ST_OVERFLOW = 3;
  localparam int unsigned ST_PARITY   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with the head entry readable combinationally; push while
// full is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL registers, TX FIFO and
// bit-timing FSM. Define UART_TX_PARITY_EN to append an even-parity bit.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = UART_TX_BASE,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_read_addr,
  output logic [15:0] o_read_data,
  output logic        o_read_sel,
  input  logic [15:0] i_write_addr,
  input  logic [15:0] i_write_data,
  input  logic        i_write_strobe,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0] CLK_MAX = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] CLK_ONE = CLK_W'(1);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  tx_state_t        state_q, state_d;
  logic [CLK_W-1:0] clk_q, clk_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             pop;
  logic             push;
  logic             overflow_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_head;
  logic [15:0]      wr_off;
  logic [15:0]      rd_off;
  logic             wr_txdata;
  logic             wr_ctrl;
  logic             rd_hit;
  logic [15:0]      status_word;
  logic [15:0]      rd_word;
  logic             unused_wdata_hi;

  assign unused_wdata_hi = ^i_write_data[15:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .push_data (i_write_data[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Offsets are computed by subtraction so an unaligned BASE_ADDR still decodes 4 words.
  assign wr_off    = i_write_addr - BASE_ADDR;
  assign rd_off    = i_read_addr - BASE_ADDR;
  assign wr_txdata = i_write_strobe && (wr_off == OFF_TXDATA);
  assign wr_ctrl   = i_write_strobe && (wr_off == OFF_CTRL);
  assign rd_hit    = (rd_off < REG_SPAN);
  assign push      = wr_txdata && (!fifo_full || pop);

  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    status_word              = '0;
    status_word[15:8]        = 8'(fifo_count);
    status_word[ST_PARITY]   = PARITY_PRESENT;
    status_word[ST_OVERFLOW] = overflow_q;
    status_word[ST_BUSY]     = o_busy;
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[ST_FULL]     = fifo_full;
  end

  always_comb begin
    rd_word = '0;
    case (rd_off)
      OFF_STATUS: rd_word = status_word;
      OFF_CTRL:   rd_word = {15'b0, overflow_q};
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_read_data <= '0;
      o_read_sel  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      o_read_data <= rd_word;
      o_read_sel  <= rd_hit;
      if (wr_txdata && !push) overflow_q <= 1'b1;
      else if (wr_ctrl)       overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      clk_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx_d is the line level for the next bit period; it is loaded at each bit boundary.
  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          clk_d   = CLK_MAX;
          bit_d   = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_head;
`endif
        end
      end
      S_START: begin
        if (clk_q != '0) begin
          clk_d = clk_q - CLK_ONE;
        end else begin
          clk_d   = CLK_MAX;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (clk_q != '0) begin
          clk_d = clk_q - CLK_ONE;
        end else begin
          clk_d = CLK_MAX;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (clk_q != '0) begin
          clk_d = clk_q - CLK_ONE;
        end else begin
          clk_d   = CLK_MAX;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (clk_q != '0) clk_d = clk_q - CLK_ONE;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: exact frame timing, register map,
// FIFO overflow, reset abort; a serial monitor checks bytes against a queue.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS    = 11;
  localparam logic [15:0] PAR_FLAG = 16'h0010;
`else
  localparam int unsigned NBITS    = 10;
  localparam logic [15:0] PAR_FLAG = 16'h0000;
`endif
  localparam int unsigned FRAME       = NBITS * CPB;
  localparam logic [15:0] STATUS_IDLE = 16'h0002 | PAR_FLAG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_read_addr;
  logic [15:0] o_read_data;
  logic        o_read_sel;
  logic [15:0] i_write_addr;
  logic [15:0] i_write_data;
  logic        i_write_strobe;
  logic        o_tx;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .BASE_ADDR    (16'h8100),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_read_addr    (i_read_addr),
    .o_read_data    (o_read_data),
    .o_read_sel     (o_read_sel),
    .i_write_addr   (i_write_addr),
    .i_write_data   (i_write_data),
    .i_write_strobe (i_write_strobe),
    .o_tx           (o_tx),
    .o_busy         (o_busy)
  );

  // Serial monitor: samples mid-bit on falling edges, pops the scoreboard per frame.
  bit         mon_active = 1'b0;
  bit         last_valid = 1'b0;
  bit         check_period = 1'b0;
  int         mon_s, mon_b, cyc, last_start;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;
`ifdef UART_TX_PARITY_EN
  logic       mon_par;
`endif

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_active = 1'b0;
        last_valid = 1'b0;
      end else if (!mon_active) begin
        if (o_tx === 1'b0) begin
          mon_active = 1'b1;
          mon_s = 0;
          if (check_period && last_valid) begin
            checks++;
            if (cyc - last_start != int'(FRAME + 1)) begin
              errors++;
              $display("FAIL frame_period: got %0d cycles, expected %0d", cyc - last_start, FRAME + 1);
            end
          end
          last_start = cyc;
          last_valid = 1'b1;
        end
      end else begin
        mon_s++;
        if (mon_s % CPB == CPB / 2) begin
          mon_b = mon_s / CPB;
          if (mon_b == 0) begin
            checks++;
            if (o_tx !== 1'b0) begin
              errors++;
              $display("FAIL start_bit: got %b, expected 0", o_tx);
            end
          end else if (mon_b <= 8) begin
            mon_byte[mon_b-1] = o_tx;
`ifdef UART_TX_PARITY_EN
          end else if (mon_b == 9) begin
            mon_par = o_tx;
`endif
          end else begin
            mon_active = 1'b0;
            checks++;
            if (o_tx !== 1'b1) begin
              errors++;
              $display("FAIL stop_bit: got %b, expected 1", o_tx);
            end
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame: got %h, expected no frame", mon_byte);
            end else begin
              mon_exp = sb.pop_front();
              if (mon_byte !== mon_exp) begin
                errors++;
                $display("FAIL frame_data: got %h, expected %h", mon_byte, mon_exp);
              end
`ifdef UART_TX_PARITY_EN
              checks++;
              if (mon_par !== ^mon_exp) begin
                errors++;
                $display("FAIL parity_bit: got %b, expected %b", mon_par, ^mon_exp);
              end
`endif
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    i_write_addr   = a;
    i_write_data   = d;
    i_write_strobe = 1'b1;
    @(posedge clk); #1;
    i_write_strobe = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d, input bit accept);
    bus_write(16'h8100, {8'hA5, d});
    if (accept) sb.push_back(d);
  endtask

  task automatic bus_read(input logic [15:0] a);
    i_read_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy !== 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, expected 0", o_busy);
    end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((sb.size() != 0 || o_busy !== 1'b0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes pending busy=%b, expected 0 and 0", sb.size(), o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_read_addr = 16'h8101;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (o_tx !== 1'b1)         begin errors++; $display("FAIL reset_tx: got %b, expected 1", o_tx); end
    if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
    if (o_read_data !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h, expected 0000", o_read_data); end
    if (o_read_sel !== 1'b0)   begin errors++; $display("FAIL reset_rsel: got %b, expected 0", o_read_sel); end
    rst_n = 1'b1;
    bus_read(16'h8101);
    checks++;
    if (o_read_data !== STATUS_IDLE) begin
      errors++;
      $display("FAIL reset_status: got %h, expected %h", o_read_data, STATUS_IDLE);
    end
  endtask

  task automatic test_read_map();
    logic [15:0] ra [7] = '{16'h8101, 16'h0000, 16'h8100, 16'h8102, 16'h8103, 16'h8104, 16'h80FF};
    logic [15:0] rd [7] = '{STATUS_IDLE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic        rs [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit saw_low = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_read(ra[i]);
      checks += 2;
      if (o_read_data !== rd[i]) begin
        errors++;
        $display("FAIL read_map_data[%h]: got %h, expected %h", ra[i], o_read_data, rd[i]);
      end
      if (o_read_sel !== rs[i]) begin
        errors++;
        $display("FAIL read_map_sel[%h]: got %b, expected %b", ra[i], o_read_sel, rs[i]);
      end
    end
    bus_write(16'h8103, 16'h00AA);
    bus_write(16'h8104, 16'h00AB);
    i_write_addr = 16'h8100;
    i_write_data = 16'h00AC;
    @(posedge clk); #1;
    bus_read(16'h8101);
    checks++;
    if (o_read_data !== STATUS_IDLE) begin
      errors++;
      $display("FAIL ignored_writes_status: got %h, expected %h", o_read_data, STATUS_IDLE);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (o_tx !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL ignored_writes_tx: got a low o_tx, expected line idle");
    end
  endtask

  task automatic test_single_frame(input logic [7:0] d);
    int   b;
    logic exp_tx;
    logic exp_busy;
    wait_idle();
    write_tx(d, 1'b1);
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL push_busy: got %b, expected 1", o_busy); end
    if (o_tx !== 1'b1)   begin errors++; $display("FAIL push_tx: got %b, expected 1", o_tx); end
    for (int c = 1; c <= int'(FRAME) + 1; c++) begin
      @(posedge clk); #1;
      b = (c - 1) / CPB;
      if (c > int'(FRAME))  exp_tx = 1'b1;
      else if (b == 0)      exp_tx = 1'b0;
      else if (b <= 8)      exp_tx = d[b-1];
`ifdef UART_TX_PARITY_EN
      else if (b == 9)      exp_tx = ^d;
`endif
      else                  exp_tx = 1'b1;
      exp_busy = (c <= int'(FRAME));
      checks += 2;
      if (o_tx !== exp_tx) begin
        errors++;
        $display("FAIL frame_tx[%h c=%0d]: got %b, expected %b", d, c, o_tx, exp_tx);
      end
      if (o_busy !== exp_busy) begin
        errors++;
        $display("FAIL frame_busy[%h c=%0d]: got %b, expected %b", d, c, o_busy, exp_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    check_period = 1'b1;
    last_valid = 1'b0;
    for (int i = 0; i < 17; i++) write_tx(8'(8'h30 + 7 * i), 1'b1);
    bus_read(16'h8101);
    checks++;
    if (o_read_data !== (16'h1005 | PAR_FLAG)) begin
      errors++;
      $display("FAIL b2b_status: got %h, expected %h", o_read_data, 16'h1005 | PAR_FLAG);
    end
    for (int i = 0; i < 17; i++) write_tx(8'(8'hC0 + i), 1'b0);
    bus_read(16'h8101);
    checks++;
    if (o_read_data !== (16'h100D | PAR_FLAG)) begin
      errors++;
      $display("FAIL overflow_status: got %h, expected %h", o_read_data, 16'h100D | PAR_FLAG);
    end
    bus_read(16'h8102);
    checks++;
    if (o_read_data !== 16'h0001) begin
      errors++;
      $display("FAIL overflow_ctrl: got %h, expected 0001", o_read_data);
    end
    bus_write(16'h8102, 16'h0000);
    bus_read(16'h8101);
    checks++;
    if (o_read_data !== (16'h1005 | PAR_FLAG)) begin
      errors++;
      $display("FAIL cleared_status: got %h, expected %h", o_read_data, 16'h1005 | PAR_FLAG);
    end
    bus_read(16'h8102);
    checks++;
    if (o_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL cleared_ctrl: got %h, expected 0000", o_read_data);
    end
    wait_drain(17 * (FRAME + 1) + 100);
    check_period = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      write_tx(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 60)) @(posedge clk);
      #1;
    end
    wait_drain(6 * (FRAME + 1) + 100);
  endtask

  task automatic test_reset_midframe();
    bit saw_low = 1'b0;
    wait_idle();
    write_tx(8'hC3, 1'b1);
    write_tx(8'h3C, 1'b1);
    repeat (17) @(posedge clk);
    #1;
    checks++;
    if (o_tx !== 1'b0) begin
      errors++;
      $display("FAIL midframe_bit3: got %b, expected 0", o_tx);
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks += 2;
    if (o_tx !== 1'b1)   begin errors++; $display("FAIL abort_tx: got %b, expected 1", o_tx); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", o_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(16'h8101);
    checks++;
    if (o_read_data !== STATUS_IDLE) begin
      errors++;
      $display("FAIL abort_status: got %h, expected %h", o_read_data, STATUS_IDLE);
    end
    repeat (2 * FRAME) begin
      @(posedge clk); #1;
      if (o_tx !== 1'b1 || o_busy !== 1'b0) saw_low = 1'b1;
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL abort_no_frame: got activity after reset, expected idle line");
    end
  endtask

  initial begin
    i_read_addr    = '0;
    i_write_addr   = '0;
    i_write_data   = '0;
    i_write_strobe = 1'b0;
    test_reset();
    test_read_map();
    test_single_frame(8'h55);
    test_single_frame(8'h07);
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
